// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the multicycle control unit: FSM state encodings,
// opcode values, pc_src / wb_data select encodings and small opcode-class
// helper functions used by both the state register and the strobe decoder.
// -----------------------------------------------------------------------------
package isa_pkg;

    // Controller states. The encoding is visible on state_o.
    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WAIT = 3'd4,
        ST_WB   = 3'd5,
        ST_TRAP = 3'd6
    } state_e;

    // Opcode values (zero-extended to the opcode field width by the user).
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_R1     = 5'd1;
    localparam logic [4:0] OP_R2     = 5'd2;
    localparam logic [4:0] OP_ADDI   = 5'd3;
    localparam logic [4:0] OP_ANDI   = 5'd4;
    localparam logic [4:0] OP_LW     = 5'd5;
    localparam logic [4:0] OP_LW_POI = 5'd6;
    localparam logic [4:0] OP_SW     = 5'd7;
    localparam logic [4:0] OP_BGT    = 5'd8;
    localparam logic [4:0] OP_BLT    = 5'd9;
    localparam logic [4:0] OP_BEQ    = 5'd10;
    localparam logic [4:0] OP_BNE    = 5'd11;
    localparam logic [4:0] OP_JMP    = 5'd12;
    localparam logic [4:0] OP_CALL   = 5'd13;
    localparam logic [4:0] OP_RET    = 5'd14;
    localparam logic [4:0] OP_PUSH   = 5'd15;
    localparam logic [4:0] OP_POP    = 5'd16;

    // pc_src encodings
    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

    // wb_data encodings
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_STACK = 2'b10;

    // Opcode is one of the 17 defined instructions.
    function automatic logic op_is_legal(input logic [31:0] opcode);
        return (opcode <= 32'd16);
    endfunction

    // R-type, ADDI and ANDI go straight from EX to WB.
    function automatic logic op_is_alu(input logic [4:0] op);
        return (op <= OP_ANDI);
    endfunction

    // Conditional branches resolve in EX.
    function automatic logic op_is_branch(input logic [4:0] op);
        return (op >= OP_BGT) && (op <= OP_BNE);
    endfunction

    // Memory read in MEM/WAIT: loads, RET (pop return address) and POP.
    function automatic logic op_mem_rd(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_LW_POI) || (op == OP_RET) || (op == OP_POP);
    endfunction

    // Memory write in MEM/WAIT: store, CALL (push return address) and PUSH.
    function automatic logic op_mem_wr(input logic [4:0] op);
        return (op == OP_SW) || (op == OP_CALL) || (op == OP_PUSH);
    endfunction

    // Memory instructions that still need a register write-back.
    function automatic logic op_mem_to_wb(input logic [4:0] op);
        return (op == OP_LW) || (op == OP_LW_POI) || (op == OP_POP);
    endfunction

    // Branch condition evaluated on the EX-cycle flags.
    function automatic logic branch_taken(input logic [4:0] op, input logic zero_f,
                                          input logic carry_f, input logic neg_f);
        logic taken;
        case (op)
            OP_BGT:  taken = ~carry_f;
            OP_BLT:  taken = neg_f;
            OP_BEQ:  taken = zero_f;
            OP_BNE:  taken = ~zero_f;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Write-back data source for instructions that reach WB.
    function automatic logic [1:0] op_wb_sel(input logic [4:0] op);
        logic [1:0] sel;
        case (op)
            OP_LW, OP_LW_POI: sel = WB_MEM;
            OP_POP:           sel = WB_STACK;
            default:          sel = WB_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Combinational strobe decoder: (state, latched opcode, flags, mem_ready)
// -> datapath strobes. Reset and stall force every strobe low; trap follows
// the TRAP state and is only cleared by reset.
// Ports:
//   i_state      current controller state
//   i_op         low 5 bits of the latched opcode
//   i_op_legal   latched opcode is a defined instruction
//   i_zero_flag, i_carry_flag, i_neg_flag   ALU flags (used in EX)
//   i_mem_ready  memory completes this cycle (used in MEM/WAIT)
//   i_stall      freeze: all strobes low
//   i_reset      synchronous reset: all outputs low
//   o_*          datapath strobes and selects, o_trap status
// -----------------------------------------------------------------------------
module ctrl_decode
    import isa_pkg::*;
(
    input  state_e     i_state,
    input  logic [4:0] i_op,
    input  logic       i_op_legal,
    input  logic       i_zero_flag,
    input  logic       i_carry_flag,
    input  logic       i_neg_flag,
    input  logic       i_mem_ready,
    input  logic       i_stall,
    input  logic       i_reset,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic [1:0] o_pc_src,
    output logic       o_j_src,
    output logic       o_ext_src,
    output logic       o_alu_src,
    output logic       o_reg_des,
    output logic [1:0] o_wb_data,
    output logic       o_reg_w1,
    output logic       o_reg_w2,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_trap
);

    logic w_active;
    logic w_taken;
    logic w_mem_jump;

    assign w_active   = ~(i_reset | i_stall);
    assign w_taken    = branch_taken(i_op, i_zero_flag, i_carry_flag, i_neg_flag);
    // CALL/RET redirect the PC in the cycle their memory access completes.
    assign w_mem_jump = i_mem_ready & ((i_op == OP_CALL) | (i_op == OP_RET));

    // Per-state strobe decode; everything defaults low.
    always_comb begin
        o_ir_write = 1'b0;
        o_pc_write = 1'b0;
        o_pc_src   = PC_SRC_INC;
        o_j_src    = 1'b0;
        o_ext_src  = 1'b0;
        o_alu_src  = 1'b0;
        o_reg_des  = 1'b0;
        o_wb_data  = WB_ALU;
        o_reg_w1   = 1'b0;
        o_reg_w2   = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_wr   = 1'b0;
        // trap is status, not a strobe: it stays visible while stalled.
        o_trap     = (i_state == ST_TRAP) & ~i_reset;
        if (w_active) begin
            case (i_state)
                ST_IF: begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    o_pc_src   = PC_SRC_INC;
                end
                ST_ID: begin
                    o_pc_write = i_op_legal & (i_op == OP_JMP);
                    o_pc_src   = (i_op_legal & (i_op == OP_JMP)) ? PC_SRC_JUMP : PC_SRC_INC;
                end
                ST_EX: begin
                    // Immediate operand for ADDI/ANDI/LW/LW.POI/SW; ANDI zero-extends.
                    o_alu_src  = (i_op >= OP_ADDI) & (i_op <= OP_SW);
                    o_ext_src  = (i_op == OP_ADDI) | (i_op == OP_LW) |
                                 (i_op == OP_LW_POI) | (i_op == OP_SW);
                    o_pc_write = w_taken;
                    o_pc_src   = w_taken ? PC_SRC_BRANCH : PC_SRC_INC;
                end
                ST_MEM, ST_WAIT: begin
                    o_mem_rd   = op_mem_rd(i_op);
                    o_mem_wr   = op_mem_wr(i_op);
                    o_pc_write = w_mem_jump;
                    o_pc_src   = w_mem_jump ? PC_SRC_JUMP : PC_SRC_INC;
                    o_j_src    = i_mem_ready & (i_op == OP_RET);
                end
                ST_WB: begin
                    o_reg_w1  = 1'b1;
                    o_reg_w2  = (i_op == OP_LW_POI);
                    o_reg_des = (i_op >= OP_ADDI) & (i_op <= OP_LW_POI);
                    o_wb_data = op_wb_sel(i_op);
                end
                default: begin
                    o_ir_write = 1'b0;
                end
            endcase
        end else begin
            o_ir_write = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Multicycle control unit: IF/ID/EX/MEM/WB sequencing with a memory-ready
// handshake (WAIT state plus optional timeout), a global stall and illegal-
// opcode trapping. Holds the state register, the opcode latch and the memory
// wait counter; strobes come from ctrl_decode.
// Parameters:
//   OPCODE_W   opcode field width (>= 5)
//   TIMEOUT_W  wait-counter width; timeout after 2**TIMEOUT_W-1 WAIT cycles
//   TIMEOUT_EN 1: TRAP on timeout, 0: wait for mem_ready indefinitely
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ir_opcode                      opcode, latched on the IF->ID edge
//   zero_flag/carry_flag/neg_flag  ALU flags, used during EX
//   stall                          freeze state/counter/opcode, strobes low
//   mem_ready                      memory access completes this cycle
//   state_o                        current state
//   ir_write .. mem_wr             datapath strobes / selects
//   trap                           sticky trap indication
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import isa_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int TIMEOUT_W  = 4,
    parameter int TIMEOUT_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                zero_flag,
    input  logic                carry_flag,
    input  logic                neg_flag,
    input  logic                stall,
    input  logic                mem_ready,
    output logic [2:0]          state_o,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                j_src,
    output logic                ext_src,
    output logic                alu_src,
    output logic                reg_des,
    output logic [1:0]          wb_data,
    output logic                reg_w1,
    output logic                reg_w2,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                trap
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = TIMEOUT_W'((2 ** TIMEOUT_W) - 1);
    // Value of the counter in the last WAIT cycle before timeout.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

    state_e                r_state;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [TIMEOUT_W-1:0]  r_cnt;

    logic                  w_op_legal;
    logic [4:0]            w_op;
    state_e                w_mem_exit;

    assign w_op_legal = op_is_legal(32'(r_opcode));
    assign w_op       = 5'(r_opcode);
    // Where a completed memory access goes next.
    assign w_mem_exit = op_mem_to_wb(w_op) ? ST_WB : ST_IF;
    assign state_o    = r_state;

    // State register, opcode latch and memory wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IF;
            r_opcode <= '0;
            r_cnt    <= '0;
        end else if (!stall) begin
            case (r_state)
                ST_IF: begin
                    r_opcode <= ir_opcode;
                    r_state  <= ST_ID;
                end
                ST_ID: begin
                    if (!w_op_legal) begin
                        r_state <= ST_TRAP;
                    end else if (w_op == OP_JMP) begin
                        r_state <= ST_IF;
                    end else begin
                        r_state <= ST_EX;
                    end
                end
                ST_EX: begin
                    if (op_is_alu(w_op)) begin
                        r_state <= ST_WB;
                    end else if (op_is_branch(w_op)) begin
                        r_state <= ST_IF;
                    end else begin
                        r_state <= ST_MEM;
                        r_cnt   <= '0;
                    end
                end
                ST_MEM: begin
                    r_state <= mem_ready ? w_mem_exit : ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        r_state <= w_mem_exit;
                    end else begin
                        // Saturating: with timeout disabled the counter parks at max.
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        if ((TIMEOUT_EN != 0) && (r_cnt == CNT_LAST)) begin
                            r_state <= ST_TRAP;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WB: begin
                    r_state <= ST_IF;
                end
                ST_TRAP: begin
                    r_state <= ST_TRAP;
                end
                default: begin
                    r_state <= ST_IF;
                end
            endcase
        end
    end

    ctrl_decode u_decode (
        .i_state      (r_state),
        .i_op         (w_op),
        .i_op_legal   (w_op_legal),
        .i_zero_flag  (zero_flag),
        .i_carry_flag (carry_flag),
        .i_neg_flag   (neg_flag),
        .i_mem_ready  (mem_ready),
        .i_stall      (stall),
        .i_reset      (reset),
        .o_ir_write   (ir_write),
        .o_pc_write   (pc_write),
        .o_pc_src     (pc_src),
        .o_j_src      (j_src),
        .o_ext_src    (ext_src),
        .o_alu_src    (alu_src),
        .o_reg_des    (reg_des),
        .o_wb_data    (wb_data),
        .o_reg_w1     (reg_w1),
        .o_reg_w2     (reg_w2),
        .o_mem_rd     (mem_rd),
        .o_mem_wr     (mem_wr),
        .o_trap       (trap)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Directed scenarios followed by a random instruction stream. The expected
// per-cycle trace of each instruction is generated from its opcode class,
// flags and memory latency; stalls are inserted as extra frozen cycles.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;
    import isa_pkg::*;

    localparam int OW   = 6;
    localparam int TW   = 2;
    localparam int WMAX = (1 << TW) - 1;   // WAIT cycles before timeout

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [OW-1:0] ir_opcode = '0;
    logic          zero_flag = 1'b0, carry_flag = 1'b0, neg_flag = 1'b0;
    logic          stall = 1'b0, mem_ready = 1'b0;
    logic [2:0]    state_o;
    logic          ir_write, pc_write, j_src, ext_src, alu_src, reg_des;
    logic          reg_w1, reg_w2, mem_rd, mem_wr, trap;
    logic [1:0]    pc_src, wb_data;
    logic [11:0]   obs;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_pct = 0;
    int cur_op = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPCODE_W(OW), .TIMEOUT_W(TW), .TIMEOUT_EN(1)) dut (
        .clk(clk), .reset(reset), .ir_opcode(ir_opcode),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag),
        .stall(stall), .mem_ready(mem_ready), .state_o(state_o),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .j_src(j_src),
        .ext_src(ext_src), .alu_src(alu_src), .reg_des(reg_des), .wb_data(wb_data),
        .reg_w1(reg_w1), .reg_w2(reg_w2), .mem_rd(mem_rd), .mem_wr(mem_wr), .trap(trap)
    );

    assign obs = {trap, ir_write, pc_write, pc_src, j_src, wb_data, reg_w1, reg_w2, mem_rd, mem_wr};

    function automatic logic [11:0] bits(bit tr, bit ir, bit pw, logic [1:0] ps, bit js,
                                         logic [1:0] wd, bit w1, bit w2, bit rd, bit wr);
        return {tr, ir, pw, ps, js, wd, w1, w2, rd, wr};
    endfunction

    task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s (op %0d): observed 'h%0h expected 'h%0h", tag, cur_op, o, e);
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cyc(string tag, state_e st, logic [11:0] e);
        #2;
        chk({tag, " state"}, 16'(state_o), 16'(st));
        chk({tag, " strobes"}, 16'(obs), 16'(e));
        @(negedge clk);
    endtask

    task automatic drive_rand();
        ir_opcode  = OW'($urandom);
        zero_flag  = 1'($urandom);
        carry_flag = 1'($urandom);
        neg_flag   = 1'($urandom);
        mem_ready  = 1'($urandom);
    endtask

    task automatic maybe_stall(state_e st, bit tr);
        if ($urandom_range(0, 99) < stall_pct) begin
            drive_rand();
            stall = 1'b1;
            cyc("stall", st, bits(tr, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0));
            stall = 1'b0;
        end
    endtask

    task automatic do_reset(int n, state_e prev, bit chk_state);
        drive_rand();
        stall = 1'($urandom);
        reset = 1'b1;
        #2;
        if (chk_state) chk("reset1 state", 16'(state_o), 16'(prev));
        chk("reset1 strobes", 16'(obs), 16'd0);
        @(negedge clk);
        for (int i = 1; i < n; i++) begin
            drive_rand();
            stall = 1'($urandom);
            cyc("reset", ST_IF, 12'd0);
        end
        reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic trap_cycles(int n);
        for (int i = 0; i < n; i++) begin
            drive_rand();
            stall = 1'($urandom);
            cyc("trap", ST_TRAP, bits(1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0));
        end
        stall = 1'b0;
    endtask

    // One instruction; k = number of not-ready memory cycles before mem_ready.
    task automatic run_instr(int op, bit z, bit c, bit n, int k, output bit trapped);
        bit taken, rd, wr, ready;
        logic [1:0] wd;
        trapped = 1'b0;
        cur_op  = op;
        maybe_stall(ST_IF, 0);
        drive_rand();
        ir_opcode = OW'(op);
        cyc("IF", ST_IF, bits(0, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0));
        maybe_stall(ST_ID, 0);
        drive_rand();
        if (op > 16) begin
            cyc("ID illegal", ST_ID, 12'd0);
            trapped = 1'b1;
            return;
        end
        if (op == 12) begin
            cyc("ID jmp", ST_ID, bits(0, 0, 1, 2'b01, 0, 2'b00, 0, 0, 0, 0));
            return;
        end
        cyc("ID", ST_ID, 12'd0);
        maybe_stall(ST_EX, 0);
        drive_rand();
        zero_flag = z; carry_flag = c; neg_flag = n;
        if (op >= 8 && op <= 11) begin
            case (op)
                8:       taken = !c;
                9:       taken = n;
                10:      taken = z;
                default: taken = !z;
            endcase
            cyc("EX branch", ST_EX, taken ? bits(0, 0, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0) : 12'd0);
            return;
        end
        cyc("EX", ST_EX, 12'd0);
        if (op > 4) begin
            rd = (op inside {5, 6, 14, 16});
            wr = (op inside {7, 13, 15});
            for (int j = 0; j <= WMAX; j++) begin
                maybe_stall(j == 0 ? ST_MEM : ST_WAIT, 0);
                drive_rand();
                ready = (j >= k);
                mem_ready = ready;
                cyc(j == 0 ? "MEM" : "WAIT", j == 0 ? ST_MEM : ST_WAIT,
                    bits(0, 0, ready && (op == 13 || op == 14),
                         (ready && (op == 13 || op == 14)) ? 2'b01 : 2'b00,
                         ready && op == 14, 2'b00, 0, 0, rd, wr));
                if (ready) break;
                if (j == WMAX) begin
                    trapped = 1'b1;
                    return;
                end
            end
            if (!(op inside {5, 6, 16})) return;
        end
        maybe_stall(ST_WB, 0);
        drive_rand();
        wd = (op == 5 || op == 6) ? 2'b01 : (op == 16) ? 2'b10 : 2'b00;
        cyc("WB", ST_WB, bits(0, 0, 0, 2'b00, 0, wd, 1, op == 6, 0, 0));
    endtask

    initial begin
        bit tr;
        // Power-up reset (state undefined in the very first cycle).
        do_reset(3, ST_IF, 0);

        // Reset held 3 cycles during EX of ADDI.
        cur_op = 3;
        drive_rand(); ir_opcode = OW'(3);
        cyc("t1 IF", ST_IF, bits(0, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0));
        drive_rand();
        cyc("t1 ID", ST_ID, 12'd0);
        do_reset(3, ST_EX, 1);

        // ADD; first cycle after reset release is IF with ir_write.
        run_instr(0, 0, 0, 0, 0, tr);
        // LW with 3 not-ready cycles (MEM + 2 WAIT low, third WAIT ready).
        run_instr(5, 0, 0, 0, 3, tr);
        // BEQ taken then not taken.
        run_instr(10, 1, 0, 0, 0, tr);
        run_instr(10, 0, 0, 0, 0, tr);
        // SW with mem_ready stuck low -> TRAP after WMAX WAIT cycles.
        run_instr(7, 0, 0, 0, 1000, tr);
        chk("sw timeout trapped", 16'(tr), 16'd1);
        trap_cycles(4);
        do_reset(2, ST_TRAP, 1);
        // Illegal opcode 6'h3F traps from ID.
        run_instr(63, 0, 0, 0, 0, tr);
        chk("illegal trapped", 16'(tr), 16'd1);
        trap_cycles(3);
        do_reset(2, ST_TRAP, 1);
        // Stall before every cycle, including WAIT.
        stall_pct = 100;
        run_instr(5, 0, 0, 0, 3, tr);
        run_instr(14, 0, 0, 0, 2, tr);
        run_instr(13, 0, 0, 0, 1, tr);
        run_instr(6, 0, 0, 0, 0, tr);
        run_instr(12, 0, 0, 0, 0, tr);

        // Random instruction stream.
        stall_pct = 20;
        for (int i = 0; i < 300; i++) begin
            int op;
            int k;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 63)) : int'($urandom_range(0, 16));
            k  = $urandom_range(0, WMAX + 1);
            run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom), k, tr);
            if (tr) begin
                trap_cycles(2);
                do_reset(2, ST_TRAP, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
